// File: rtl/nzcv_cond_unit.sv
// nzcv_cond_unit: architectural NZCV flag register plus an ARM-style
// condition-code evaluator behind a valid/ready query handshake.
//
// Ports:
//   clk, rst                 - rising-edge clock, synchronous active-high reset
//   flag_we, flag_in[3:0]    - flag write from the ALU, ordered {N,Z,C,V}
//   flag_pend                - flag-setting op in flight; stalls queries
//   q_valid, q_cond[3:0]     - condition query (input side)
//   q_ready                  - combinational accept indication
//   r_valid, r_pass, r_cond  - registered result, 1-cycle latency
//   r_ready                  - downstream accepts the result
//   nzcv[3:0]                - current flag register
module nzcv_cond_unit #(
    parameter bit         BYPASS      = 1'b1,
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flag_we,
    input  logic [3:0] flag_in,
    input  logic       flag_pend,
    input  logic       q_valid,
    input  logic [3:0] q_cond,
    output logic       q_ready,
    output logic       r_valid,
    output logic       r_pass,
    output logic [3:0] r_cond,
    input  logic       r_ready,
    output logic [3:0] nzcv
);

    localparam int unsigned FLAG_W = 4;
    localparam int unsigned COND_W = 4;

    logic              accept_c;
    logic [FLAG_W-1:0] eval_flags_c;
    logic              pass_c;

    // Full 16-entry decode of the condition code against {N,Z,C,V}.
    function automatic logic cond_eval(input logic [COND_W-1:0] cond,
                                       input logic [FLAG_W-1:0] f);
        logic n, z, c, v;
        logic res;
        n   = f[3];
        z   = f[2];
        c   = f[1];
        v   = f[0];
        res = 1'b0;
        case (cond)
            4'h0: res = z;
            4'h1: res = !z;
            4'h2: res = c;
            4'h3: res = !c;
            4'h4: res = n;
            4'h5: res = !n;
            4'h6: res = v;
            4'h7: res = !v;
            4'h8: res = c && !z;
            4'h9: res = !c || z;
            4'hA: res = (n == v);
            4'hB: res = (n != v);
            4'hC: res = !z && (n == v);
            4'hD: res = z || (n != v);
            4'hE: res = 1'b1;
            4'hF: res = 1'b0;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    // Accept only when not stalled and the result slot is free or draining.
    assign q_ready = !rst && !flag_pend && (!r_valid || r_ready);

    // Evaluation flags: same-cycle bypass of an incoming flag write when enabled.
    always_comb begin
        accept_c     = 1'b0;
        eval_flags_c = nzcv;
        pass_c       = 1'b0;
        accept_c     = q_valid && q_ready;
        if (BYPASS && flag_we) begin
            eval_flags_c = flag_in;
        end
        pass_c = cond_eval(q_cond, eval_flags_c);
    end

    // Flag register and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            nzcv    <= RESET_FLAGS;
            r_valid <= 1'b0;
            r_pass  <= 1'b0;
            r_cond  <= COND_W'(0);
        end else begin
            if (flag_we) begin
                nzcv <= flag_in;
            end
            if (accept_c) begin
                r_valid <= 1'b1;
                r_pass  <= pass_c;
                r_cond  <= q_cond;
            end else if (r_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/nzcv_cond_unit.md
Name: nzcv_cond_unit

Overview:
- Consumer end of the 4-bit NZCV flag interface driven by the 32-bit adder/ALU.
- Holds the architectural flag register and evaluates 4-bit ARM-style condition codes against it for branch and conditional-execute logic.
- Queries use a valid/ready handshake. Results are registered with 1-cycle latency.
- Supports same-cycle flag bypass and stalls while a flag-setting op is in flight upstream.

Parameters:
- BYPASS, 1, 1 = a query accepted in the same cycle as a flag write evaluates against flag_in; 0 = it evaluates against the old register value.
- RESET_FLAGS, 4'b0000, reset value of the flag register, ordered {N,Z,C,V}.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- flag_we  input  1  ALU flag-write strobe (flag-setting op completing).
- flag_in  input  4  NZCV from the adder: [3]=N [2]=Z [1]=C [0]=V.
- flag_pend  input  1  a flag-setting op is issued but not yet written; queries must stall.
- q_valid  input  1  condition query present.
- q_cond  input  4  condition code to evaluate.
- q_ready  output  1  query accepted this cycle when q_valid && q_ready.
- r_valid  output  1  result valid.
- r_pass  output  1  1 = condition true.
- r_cond  output  4  echo of the evaluated q_cond.
- r_ready  input  1  downstream accepts the result.
- nzcv  output  4  current flag register.

Behaviour:
- Reset: all of the following take effect on the clock edge with rst=1.
  - nzcv=RESET_FLAGS; r_valid=0; r_pass=0; r_cond=0.
  - q_ready evaluates to 0 during the reset cycle.
  - Any query presented in the reset cycle is dropped.
  - Reset mid-handshake discards the pending result.
- Flag register: on flag_we=1, nzcv <= flag_in at the next edge. Otherwise it holds.
- q_ready = !rst && !flag_pend && (!r_valid || r_ready). This is combinational; it has no path from q_valid.
- Accept (q_valid && q_ready):
  - Evaluation flags: f = (BYPASS && flag_we) ? flag_in : nzcv.
  - At the next edge: r_valid<=1, r_pass<=eval(q_cond,f), r_cond<=q_cond. Latency is exactly 1 cycle.
- Hold: while r_valid && !r_ready, r_valid, r_pass and r_cond are stable and q_ready=0.
- Retire:
  - r_valid && r_ready with no new accept: r_valid<=0 next edge.
  - r_valid && r_ready with a new accept in the same cycle: the next result is loaded back-to-back, giving a throughput of 1 per cycle.
- flag_pend=1 forces q_ready=0 regardless of flag_we. The team requires upstream to deassert flag_pend in the same cycle as the final flag_we, so bypass covers that cycle.
- A flag write during a held result does not alter r_pass. The result reflects the flags at accept time.
- Condition table, with f={N,Z,C,V}:
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C.
  - 4 MI N; 5 PL !N; 6 VS V; 7 VC !V.
  - 8 HI C&!Z; 9 LS !C|Z.
  - A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V).
  - E AL 1; F NV 0.
- No X propagation: an undefined cond is impossible because all 16 codes are decoded.

Test Plan:
- Reset then query q_cond=4'hE -> 1 cycle later r_valid=1, r_pass=1, r_cond=E. nzcv=0000. Query 0 (EQ) -> r_pass=0.
- Write flag_in=4'b0100 (Z), then sweep all 16 conds back-to-back with r_ready=1:
  - r_pass pattern for cond 0..F = 1,0,0,1,0,1,0,1,0,1,1,0,0,1,1,0.
  - One result per cycle.
- Same-cycle bypass: nzcv=0000; flag_we=1, flag_in=4'b1000, q_cond=B (LT) accepted that cycle:
  - BYPASS=1 -> r_pass=1.
  - BYPASS=0 -> r_pass=0.
- Backpressure: result valid with r_ready=0 for 3 cycles, flag_we toggling flags meanwhile:
  - r_pass and r_cond are unchanged and q_ready=0.
  - Raising r_ready retires the result, with a new query accepted in the same cycle.
- flag_pend=1 for 4 cycles with q_valid=1 -> q_ready=0 throughout.
  - Pend drops with flag_we=1, flag_in=4'b0010 -> the query is accepted that cycle; q_cond=2 (CS) gives r_pass=1.
- rst asserted while r_valid=1 and r_ready=0:
  - Next cycle r_valid=0 and nzcv=RESET_FLAGS.
  - A query presented in the reset cycle never produces a result.
